// File: rtl/dm_arbiter.sv
// Two-master (CPU/DMA) round-robin arbiter in front of a single-ported synchronous data memory.
// One access in flight: IDLE samples and latches, ISSUE grants and strobes memory, RESP returns.
module dm_arbiter #(
   parameter logic [31:0] ADDR_LO = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI = 32'h0000_2fff
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0]  state;
   logic        last_grant;
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_be;

   logic        pick;
   logic        in_range;
   logic        issue;
   logic        resp;
   logic [31:0] resp_data;

   // m1 wins when it is the only requester, or on a tie when m0 was granted last.
   assign pick = m1_req && (!m0_req || !last_grant);

   // Offset compare gives an inclusive unsigned window without a constant-zero comparison.
   assign in_range = (cmd_addr - ADDR_LO) <= (ADDR_HI - ADDR_LO);

   assign issue = (state == ISSUE);
   assign resp  = (state == RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cmd_we     <= 1'b0;
         cmd_addr   <= 32'h0;
         cmd_wdata  <= 32'h0;
         cmd_be     <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state      <= ISSUE;
                  last_grant <= pick;
                  cmd_we     <= pick ? m1_we    : m0_we;
                  cmd_addr   <= pick ? m1_addr  : m0_addr;
                  cmd_wdata  <= pick ? m1_wdata : m0_wdata;
                  cmd_be     <= pick ? m1_be    : m0_be;
               end
            end
            ISSUE:   state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_en    = issue && in_range;
      mem_we    = mem_en && cmd_we;
      mem_addr  = mem_en ? {cmd_addr[31:2], 2'b00} : 32'h0;
      mem_wdata = mem_en ? cmd_wdata : 32'h0;
      mem_be    = mem_en ? cmd_be : 4'h0;
   end

   always_comb begin
      resp_data = (in_range && !cmd_we) ? mem_rdata : 32'h0;
      m0_gnt    = issue && !last_grant;
      m1_gnt    = issue && last_grant;
      m0_rvalid = resp && !last_grant;
      m1_rvalid = resp && last_grant;
      m0_rdata  = m0_rvalid ? resp_data : 32'h0;
      m1_rdata  = m1_rvalid ? resp_data : 32'h0;
      m0_err    = m0_rvalid && !in_range;
      m1_err    = m1_rvalid && !in_range;
   end

endmodule
